sram_access_ctrl: RTL and testbench

- Sequencing controller for the SRAM macro. Drives the precharge, row-decoder enable, column-decoder enable, write-driver enable and sense-amp enable in a fixed phase order.
- Accepts one read or write request at a time over a valid/ready handshake and returns the result over a valid/ready response channel.
- Sits between the Tiny Tapeout user interface logic and the row decoder, column decoder and bit-cell array.

---
 rtl/sram_ctrl_pkg.sv | 19 +
 rtl/phase_timer.sv | 27 ++
 rtl/sram_access_ctrl.sv | 120 ++++++++++++
 tb/tb_sram_access_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM access sequencer: FSM state encoding and
// default phase timing.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ACC  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int PRE_CYCLES_DEF = 1;
  localparam int ACC_CYCLES_DEF = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times the precharge and access phases; it holds
// at zero until the next load.
module phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// SRAM phase sequencer: precharge, then wordline/column access, then a held
// response, with one request in flight at a time.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ROW_ADDR_WIDTH = 4,
  parameter int COL_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH     = 1,
  parameter int PRE_CYCLES     = PRE_CYCLES_DEF,
  parameter int ACC_CYCLES     = ACC_CYCLES_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic                                   req_we,
  input  logic [ROW_ADDR_WIDTH+COL_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]                  req_wdata,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [DATA_WIDTH-1:0]                  rsp_rdata,
  output logic [ROW_ADDR_WIDTH-1:0]              row_addr,
  output logic                                   row_en,
  output logic [COL_ADDR_WIDTH-1:0]              col_addr,
  output logic                                   col_en,
  output logic                                   precharge_en,
  output logic                                   write_en,
  output logic [DATA_WIDTH-1:0]                  wdata,
  output logic                                   sense_en,
  input  logic [DATA_WIDTH-1:0]                  sense_data,
  output logic                                   busy
);

  localparam int CNT_WIDTH = $clog2(max_int(PRE_CYCLES, ACC_CYCLES)) + 1;
  localparam logic [CNT_WIDTH-1:0] PRE_LOAD = CNT_WIDTH'(PRE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ACC_LOAD = CNT_WIDTH'(ACC_CYCLES - 1);

  state_t                 state, state_next;
  logic                   we_q;
  logic                   accept;
  logic                   timer_load;
  logic [CNT_WIDTH-1:0]   timer_val;
  logic                   timer_zero;

  phase_timer #(.WIDTH(CNT_WIDTH)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  assign accept = (state == IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_addr  <= '0;
      col_addr  <= '0;
      wdata     <= '0;
      we_q      <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        row_addr  <= req_addr[ROW_ADDR_WIDTH+COL_ADDR_WIDTH-1:COL_ADDR_WIDTH];
        col_addr  <= req_addr[COL_ADDR_WIDTH-1:0];
        wdata     <= req_wdata;
        we_q      <= req_we;
        // Cleared here so a write response reports zero read data.
        rsp_rdata <= '0;
      end
      if ((state == ACC) && timer_zero && !we_q) begin
        rsp_rdata <= sense_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_val  = PRE_LOAD;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = PRE;
          timer_load = 1'b1;
          timer_val  = PRE_LOAD;
        end
      end
      PRE: begin
        if (timer_zero) begin
          state_next = ACC;
          timer_load = 1'b1;
          timer_val  = ACC_LOAD;
        end
      end
      ACC: begin
        if (timer_zero) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign precharge_en = (state == PRE);
  assign row_en       = (state == ACC);
  assign col_en       = (state == ACC);
  assign write_en     = (state == ACC) && we_q;
  assign sense_en     = (state == ACC) && !we_q && timer_zero;
  assign rsp_valid    = (state == RESP);

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: default-timing instance plus a PRE=3/ACC=1
// instance, with response data checked through per-instance scoreboards.
module tb_sram_access_ctrl;

  logic       clk;
  logic       rst;

  logic       req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [7:0] req_addr;
  logic [0:0] req_wdata, rsp_rdata, wdata, sense_data;
  logic [3:0] row_addr, col_addr;
  logic       row_en, col_en, precharge_en, write_en, sense_en, busy;

  logic       p_req_valid, p_req_ready, p_req_we, p_rsp_valid, p_rsp_ready;
  logic [7:0] p_req_addr;
  logic [0:0] p_req_wdata, p_rsp_rdata, p_wdata, p_sense_data;
  logic [3:0] p_row_addr, p_col_addr;
  logic       p_row_en, p_col_en, p_precharge_en, p_write_en, p_sense_en, p_busy;

  int         checks = 0;
  int         errors = 0;
  logic [0:0] sbq  [$];
  logic [0:0] sbq1 [$];
  int         acc_cyc [$];
  logic [7:0] b2b_addr [2];
  logic [7:0] cur;
  int         n;

  sram_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .row_addr(row_addr), .row_en(row_en), .col_addr(col_addr), .col_en(col_en),
    .precharge_en(precharge_en), .write_en(write_en), .wdata(wdata),
    .sense_en(sense_en), .sense_data(sense_data), .busy(busy)
  );

  sram_access_ctrl #(.PRE_CYCLES(3), .ACC_CYCLES(1)) dut_slow (
    .clk(clk), .rst(rst),
    .req_valid(p_req_valid), .req_ready(p_req_ready), .req_we(p_req_we),
    .req_addr(p_req_addr), .req_wdata(p_req_wdata),
    .rsp_valid(p_rsp_valid), .rsp_ready(p_rsp_ready), .rsp_rdata(p_rsp_rdata),
    .row_addr(p_row_addr), .row_en(p_row_en), .col_addr(p_col_addr), .col_en(p_col_en),
    .precharge_en(p_precharge_en), .write_en(p_write_en), .wdata(p_wdata),
    .sense_en(p_sense_en), .sense_data(p_sense_data), .busy(p_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response scoreboards and the precharge/wordline exclusion, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("pre_row_overlap", 32'(precharge_en & row_en), 32'(0));
      if (rsp_valid && rsp_ready) begin
        check("sb_nonempty", 32'(sbq.size() != 0), 32'(1));
        if (sbq.size() != 0) check("rsp_rdata", 32'(rsp_rdata), 32'(sbq.pop_front()));
      end
      if (p_rsp_valid && p_rsp_ready) begin
        check("sb1_nonempty", 32'(sbq1.size() != 0), 32'(1));
        if (sbq1.size() != 0) check("p_rsp_rdata", 32'(p_rsp_rdata), 32'(sbq1.pop_front()));
      end
    end
  end

  task automatic run_req(input logic we, input logic [7:0] addr, input logic wd, input logic sd);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    rsp_ready = 1'b1; sense_data = 1'b0;
    sbq.push_back(we ? 1'b0 : sd);
    tick();
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd;
    check("c1_enables", 32'({precharge_en, row_en, col_en, write_en, sense_en}), 32'(5'b10000));
    tick();
    check("c2_enables", 32'({precharge_en, row_en, col_en, write_en, sense_en}),
          32'({1'b0, 1'b1, 1'b1, we, 1'b0}));
    check("c2_addr", 32'({row_addr, col_addr}), 32'(addr));
    if (we) check("c2_wdata", 32'(wdata), 32'(wd));
    tick();
    sense_data = sd;
    check("c3_enables", 32'({precharge_en, row_en, col_en, write_en, sense_en}),
          32'({1'b0, 1'b1, 1'b1, we, ~we}));
    tick();
    sense_data = 1'b0;
    check("c4_rsp", 32'({rsp_valid, req_ready, busy}), 32'(3'b101));
    tick();
    check("c5_idle", 32'({rsp_valid, req_ready, busy}), 32'(3'b010));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; sense_data = '0;
    p_req_valid = 1'b0; p_req_we = 1'b0; p_req_addr = '0; p_req_wdata = '0;
    p_rsp_ready = 1'b1; p_sense_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready_busy", 32'({req_ready, busy, rsp_valid}), 32'(3'b100));
    check("rst_enables", 32'({precharge_en, row_en, col_en, write_en, sense_en}), 32'(0));
    check("rst_addr_data", 32'({row_addr, col_addr, wdata, rsp_rdata}), 32'(0));

    // Write then read of 0x3A; the write sees sense_data=1 and must still return 0.
    run_req(1'b1, 8'h3A, 1'b1, 1'b1);
    run_req(1'b0, 8'h3A, 1'b0, 1'b1);

    // Response stall with a competing request.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h55; rsp_ready = 1'b0; sense_data = 1'b0;
    sbq.push_back(1'b1);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    sense_data = 1'b1;
    tick();
    sense_data = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h11;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'({rsp_valid, req_ready}), 32'(2'b10));
      check("stall_rdata", 32'(rsp_rdata), 32'(1));
      check("stall_enables", 32'({precharge_en, row_en, col_en, write_en, sense_en}), 32'(0));
      check("stall_addr", 32'({row_addr, col_addr}), 32'(8'h55));
      tick();
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    tick();
    check("stall_release", 32'({req_ready, busy, rsp_valid}), 32'(3'b100));
    check("stall_no_accept", 32'({row_addr, col_addr}), 32'(8'h55));

    // Reset during the access phase of a write.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h21; req_wdata = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("abort_in_acc", 32'(row_en), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_enables", 32'({precharge_en, row_en, col_en, write_en, sense_en}), 32'(0));
    check("abort_state", 32'({busy, req_ready, rsp_valid}), 32'(3'b010));
    check("abort_cleared", 32'({row_addr, col_addr, wdata}), 32'(0));
    for (int i = 0; i < 6; i++) begin
      check("abort_no_rsp", 32'(rsp_valid), 32'(0));
      tick();
    end
    run_req(1'b0, 8'h21, 1'b0, 1'b0);

    // Back-to-back reads with req_valid held high.
    b2b_addr[0] = 8'h00; b2b_addr[1] = 8'hFF;
    req_valid = 1'b1; req_we = 1'b0; sense_data = 1'b1; rsp_ready = 1'b1;
    n = 0; cur = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (req_valid && req_ready) begin
        req_addr = b2b_addr[n]; cur = b2b_addr[n];
        acc_cyc.push_back(i); sbq.push_back(1'b1); n++;
      end
      tick();
      if (n == 2) req_valid = 1'b0;
      if (row_en) check("b2b_addr", 32'({row_addr, col_addr}), 32'(cur));
    end
    sense_data = 1'b0;
    check("b2b_count", 32'(n), 32'(2));
    if (acc_cyc.size() == 2) check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(5));

    // PRE_CYCLES=3, ACC_CYCLES=1 read.
    p_req_valid = 1'b1; p_req_we = 1'b0; p_req_addr = 8'h3A; p_sense_data = 1'b1;
    sbq1.push_back(1'b1);
    tick();
    p_req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("slow_pre", 32'({p_precharge_en, p_row_en, p_sense_en, p_rsp_valid}), 32'(4'b1000));
      tick();
    end
    check("slow_acc", 32'({p_precharge_en, p_row_en, p_sense_en, p_rsp_valid}), 32'(4'b0110));
    tick();
    p_sense_data = 1'b0;
    check("slow_rsp", 32'({p_precharge_en, p_row_en, p_sense_en, p_rsp_valid}), 32'(4'b0001));
    check("slow_rdata", 32'(p_rsp_rdata), 32'(1));
    tick();
    check("slow_idle", 32'({p_req_ready, p_busy}), 32'(2'b10));

    check("sb_drain", 32'(sbq.size()), 32'(0));
    check("sb1_drain", 32'(sbq1.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
